// File: rtl/pid_if.sv
// Sample-in / PID-out bus for the heading PID sequencer.
// master: sensor + integrator side (drives heading sample and I_term)
// slave : pid_seq (returns err_sat/err_vld, PID/pid_vld, busy, ovr)
interface pid_if;
  logic               hdng_vld;
  logic signed [11:0] heading;
  logic signed [11:0] dsrd_hdng;
  logic               moving;
  logic signed [8:0]  I_term;
  logic signed [9:0]  err_sat;
  logic               err_vld;
  logic signed [13:0] PID;
  logic               pid_vld;
  logic               busy;
  logic               ovr;

  modport master (
    output hdng_vld, heading, dsrd_hdng, moving, I_term,
    input  err_sat, err_vld, PID, pid_vld, busy, ovr
  );

  modport slave (
    input  hdng_vld, heading, dsrd_hdng, moving, I_term,
    output err_sat, err_vld, PID, pid_vld, busy, ovr
  );
endinterface

// File: rtl/pid_seq.sv
// Per-sample heading PID sequencer: forms and saturates the heading error,
// pulses err_vld (decimated) to the integrator, builds P and D terms and sums
// P + I + D on one shared accumulator into a saturated, registered PID word.
// Ports: clk, rst_n (async active-low), bus (pid_if.slave: sample in,
//        err_sat/err_vld, PID/pid_vld, busy, sticky ovr out).
module pid_seq #(
  parameter int unsigned I_DECIM = 4,
  parameter int unsigned D_DEPTH = 2,
  parameter int unsigned P_COEFF = 3,
  parameter int unsigned D_COEFF = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  pid_if.slave  bus
);

  localparam int unsigned HW    = 12;
  localparam int unsigned EW    = 10;
  localparam int unsigned DW    = 7;
  localparam int unsigned TW    = 12;
  localparam int unsigned AW    = 15;
  localparam int unsigned PW    = 14;
  localparam int unsigned CNT_W = (I_DECIM > 1) ? $clog2(I_DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(I_DECIM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_DIFF, S_ACC_P, S_ACC_I, S_ACC_D
  } state_t;

  state_t state_q, state_d;

  logic                    ld_c, do_err_c, do_diff_c, do_accp_c, do_acci_c, do_accd_c;
  logic                    ovr_set_c;

  logic signed [HW-1:0]    hdng_q, dsrd_q;
  logic                    mv_q;
  logic [CNT_W-1:0]        dec_cnt_q;
  logic signed [EW-1:0]    hist_q [D_DEPTH];
  logic signed [TW-1:0]    d_term_q;
  logic signed [AW-1:0]    acc_q;

  logic signed [EW-1:0]    err_sat_q;
  logic                    err_vld_q;
  logic signed [PW-1:0]    pid_q;
  logic                    pid_vld_q;
  logic                    busy_q;
  logic                    ovr_q;

  logic signed [HW:0]      err_c;
  logic signed [EW:0]      diff_c;
  logic signed [DW-1:0]    d_sat_c;
  logic signed [TW-1:0]    d_term_c;
  logic signed [AW-1:0]    p_c, sum_i_c, sum_d_c;

  function automatic logic signed [EW-1:0] sat_err(input logic signed [HW:0] v);
    if (v > 13'sd511)       return 10'sd511;
    else if (v < -13'sd512) return -10'sd512;
    else                    return $signed(v[EW-1:0]);
  endfunction

  function automatic logic signed [PW-1:0] sat_pid(input logic signed [AW-1:0] v);
    if (v > 15'sd8191)       return 14'sd8191;
    else if (v < -15'sd8192) return -14'sd8192;
    else                     return $signed(v[PW-1:0]);
  endfunction

  // Datapath arithmetic shared by the sequence steps
  always_comb begin
    err_c  = {hdng_q[HW-1], hdng_q} - {dsrd_q[HW-1], dsrd_q};
    diff_c = {err_sat_q[EW-1], err_sat_q} - {hist_q[D_DEPTH-1][EW-1], hist_q[D_DEPTH-1]};
    if (diff_c > 11'sd63)       d_sat_c = 7'sd63;
    else if (diff_c < -11'sd64) d_sat_c = -7'sd64;
    else                        d_sat_c = $signed(diff_c[DW-1:0]);
    d_term_c = TW'(d_sat_c) * $signed(TW'(D_COEFF));
    p_c      = AW'(err_sat_q) * $signed(AW'(P_COEFF));
    sum_i_c  = acc_q + AW'(bus.I_term);
    sum_d_c  = acc_q + AW'(d_term_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.hdng_vld) state_d = S_ERR;
      S_ERR:   state_d = S_DIFF;
      S_DIFF:  state_d = S_ACC_P;
      S_ACC_P: state_d = S_ACC_I;
      S_ACC_I: state_d = S_ACC_D;
      S_ACC_D: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state datapath enables
  always_comb begin
    ld_c      = 1'b0;
    do_err_c  = 1'b0;
    do_diff_c = 1'b0;
    do_accp_c = 1'b0;
    do_acci_c = 1'b0;
    do_accd_c = 1'b0;
    ovr_set_c = 1'b0;
    case (state_q)
      S_IDLE:  ld_c      = bus.hdng_vld;
      S_ERR:   do_err_c  = 1'b1;
      S_DIFF:  do_diff_c = 1'b1;
      S_ACC_P: do_accp_c = 1'b1;
      S_ACC_I: do_acci_c = 1'b1;
      S_ACC_D: do_accd_c = 1'b1;
      default: ;
    endcase
    // A sample arriving mid-sequence is dropped but remembered
    if (state_q != S_IDLE && bus.hdng_vld) ovr_set_c = 1'b1;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdng_q    <= '0;
      dsrd_q    <= '0;
      mv_q      <= 1'b0;
      dec_cnt_q <= '0;
      for (int i = 0; i < int'(D_DEPTH); i++) hist_q[i] <= '0;
      d_term_q  <= '0;
      acc_q     <= '0;
      err_sat_q <= '0;
      err_vld_q <= 1'b0;
      pid_q     <= '0;
      pid_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      err_vld_q <= 1'b0;
      pid_vld_q <= 1'b0;
      busy_q    <= (state_d != S_IDLE);
      if (ovr_set_c) ovr_q <= 1'b1;
      if (ld_c) begin
        hdng_q <= bus.heading;
        dsrd_q <= bus.dsrd_hdng;
        mv_q   <= bus.moving;
      end
      if (do_err_c) begin
        err_sat_q <= sat_err(err_c);
        if (!mv_q) begin
          dec_cnt_q <= '0;
        end else if (dec_cnt_q == CNT_LAST) begin
          err_vld_q <= 1'b1;
          dec_cnt_q <= '0;
        end else begin
          dec_cnt_q <= dec_cnt_q + CNT_W'(1);
        end
      end
      if (do_diff_c) begin
        // Stationary samples wipe the history so D restarts cleanly
        if (mv_q) begin
          d_term_q  <= d_term_c;
          hist_q[0] <= err_sat_q;
          for (int i = 1; i < int'(D_DEPTH); i++) hist_q[i] <= hist_q[i-1];
        end else begin
          d_term_q <= '0;
          for (int i = 0; i < int'(D_DEPTH); i++) hist_q[i] <= '0;
        end
      end
      if (do_accp_c) acc_q <= p_c;
      if (do_acci_c) acc_q <= sum_i_c;
      if (do_accd_c) begin
        pid_q     <= sat_pid(sum_d_c);
        pid_vld_q <= 1'b1;
      end
    end
  end

  assign bus.err_sat = err_sat_q;
  assign bus.err_vld = err_vld_q;
  assign bus.PID     = pid_q;
  assign bus.pid_vld = pid_vld_q;
  assign bus.busy    = busy_q;
  assign bus.ovr     = ovr_q;

endmodule

// File: tb/tb_pid_seq.sv
// Bench for pid_seq: two instances (default gains, and high gains/deeper
// history) share one stimulus stream and are checked every cycle against a
// sample-level model, plus hand-computed literal checkpoints.
module tb_pid_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               hdng_vld;
  logic               moving;
  logic signed [11:0] heading, dsrd_hdng;
  logic signed [8:0]  I_term;
  logic               cmp_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses [2];

  localparam int M_ID [2] = '{4, 3};
  localparam int M_DD [2] = '{2, 3};
  localparam int M_PC [2] = '{3, 15};
  localparam int M_DC [2] = '{2, 15};

  pid_if bus0 ();
  pid_if bus1 ();

  assign bus0.hdng_vld  = hdng_vld;
  assign bus0.heading   = heading;
  assign bus0.dsrd_hdng = dsrd_hdng;
  assign bus0.moving    = moving;
  assign bus0.I_term    = I_term;
  assign bus1.hdng_vld  = hdng_vld;
  assign bus1.heading   = heading;
  assign bus1.dsrd_hdng = dsrd_hdng;
  assign bus1.moving    = moving;
  assign bus1.I_term    = I_term;

  pid_seq #(.I_DECIM(4), .D_DEPTH(2), .P_COEFF(3), .D_COEFF(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  pid_seq #(.I_DECIM(3), .D_DEPTH(3), .P_COEFF(15), .D_COEFF(15)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  // Model state: m_t counts clocks since a sample was accepted (0 = idle)
  int m_t [2], m_err [2], m_vld [2], m_pid [2], m_pvld [2], m_ovr [2], m_cnt [2];
  int m_hist [2][8];
  int p_err [2], p_pulse [2], p_dt [2], p_i [2];

  function automatic int sat(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample-level reference: whole sample computed on acceptance, results
  // released at the clock offsets where they become visible.
  always @(posedge clk or negedge rst_n) begin
    int e, d;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_t[k] = 0; m_err[k] = 0; m_vld[k] = 0; m_pid[k] = 0; m_pvld[k] = 0;
        m_ovr[k] = 0; m_cnt[k] = 0;
        for (int j = 0; j < 8; j++) m_hist[k][j] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_vld[k]  = 0;
        m_pvld[k] = 0;
        if (m_t[k] == 0) begin
          if (hdng_vld) begin
            e = sat(int'(heading) - int'(dsrd_hdng), -512, 511);
            p_err[k]   = e;
            p_pulse[k] = 0;
            if (moving) begin
              if (m_cnt[k] == M_ID[k] - 1) begin
                p_pulse[k] = 1;
                m_cnt[k]   = 0;
              end else begin
                m_cnt[k]++;
              end
              d = sat(e - m_hist[k][M_DD[k]-1], -64, 63);
              p_dt[k] = d * M_DC[k];
              for (int j = 7; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
              m_hist[k][0] = e;
            end else begin
              m_cnt[k] = 0;
              p_dt[k]  = 0;
              for (int j = 0; j < 8; j++) m_hist[k][j] = 0;
            end
            m_t[k] = 1;
          end
        end else begin
          if (hdng_vld) m_ovr[k] = 1;
          case (m_t[k])
            1: begin m_err[k] = p_err[k]; m_vld[k] = p_pulse[k]; end
            4: p_i[k] = int'(I_term);
            5: begin
                 m_pid[k]  = sat(p_err[k] * M_PC[k] + p_i[k] + p_dt[k], -8192, 8191);
                 m_pvld[k] = 1;
               end
            default: ;
          endcase
          m_t[k] = (m_t[k] == 5) ? 0 : m_t[k] + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("err_sat0", int'(bus0.err_sat), m_err[0]);
      chk("err_vld0", int'(bus0.err_vld), m_vld[0]);
      chk("PID0",     int'(bus0.PID),     m_pid[0]);
      chk("pid_vld0", int'(bus0.pid_vld), m_pvld[0]);
      chk("busy0",    int'(bus0.busy),    int'(m_t[0] != 0));
      chk("ovr0",     int'(bus0.ovr),     m_ovr[0]);
      chk("err_sat1", int'(bus1.err_sat), m_err[1]);
      chk("err_vld1", int'(bus1.err_vld), m_vld[1]);
      chk("PID1",     int'(bus1.PID),     m_pid[1]);
      chk("pid_vld1", int'(bus1.pid_vld), m_pvld[1]);
      chk("busy1",    int'(bus1.busy),    int'(m_t[1] != 0));
      chk("ovr1",     int'(bus1.ovr),     m_ovr[1]);
      if (bus0.err_vld) pulses[0]++;
      if (bus1.err_vld) pulses[1]++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hdng_vld = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Present one sample for one clock; returns just after the sampling edge
  task automatic send(input logic [11:0] h, input logic [11:0] dh,
                      input logic mv, input logic [8:0] it);
    heading   = h;
    dsrd_hdng = dh;
    moving    = mv;
    I_term    = it;
    hdng_vld  = 1'b1;
    tick();
    hdng_vld  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; hdng_vld = 1'b0; moving = 1'b0;
    heading = '0; dsrd_hdng = '0; I_term = '0;
    repeat (2) tick();
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Basic sample after reset
    chk("reset_busy0", int'(bus0.busy), 0);
    send(12'h100, 12'h000, 1'b1, 9'd0);
    tick();
    chk("t1_err_sat", int'(bus0.err_sat), 256);
    chk("t1_err_vld", int'(bus0.err_vld), 0);
    repeat (4) tick();
    chk("t1_pid_vld", int'(bus0.pid_vld), 1);
    chk("t1_PID",     int'(bus0.PID), 894);

    // Error saturation both ways, PID saturation both ways
    do_reset();
    send(12'h7FF, 12'h800, 1'b1, 9'd255);
    repeat (5) tick();
    chk("t2_err_pos",  int'(bus0.err_sat), 511);
    chk("t2_PID0",     int'(bus0.PID), 1914);
    chk("t2_PID1_sat", int'(bus1.PID), 8191);
    send(12'h800, 12'h7FF, 1'b1, 9'd255);
    repeat (5) tick();
    chk("t2_err_neg",  int'(bus0.err_sat), -512);
    chk("t2_PID0_neg", int'(bus0.PID), -1409);
    chk("t2_PID1_neg", int'(bus1.PID), -8192);

    // Integrator decimation over eight back-to-back samples
    do_reset();
    pulses[0] = 0;
    pulses[1] = 0;
    for (int s = 0; s < 8; s++) begin
      send(12'($urandom_range(0, 400)), 12'd100, 1'b1, 9'($urandom));
      repeat (5) tick();
    end
    chk("t3_pulses0", pulses[0], 2);
    chk("t3_pulses1", pulses[1], 2);

    // Stationary sample clears history; next moving sample D saturates low
    send(12'h123, 12'h000, 1'b0, 9'd0);
    repeat (5) tick();
    send(12'(-300), 12'h000, 1'b1, 9'd0);
    repeat (5) tick();
    chk("t4_PID0", int'(bus0.PID), -1028);

    // Overlapping sample is dropped and flagged
    send(12'h050, 12'h000, 1'b1, 9'd0);
    tick();
    heading = 12'h3FF;
    hdng_vld = 1'b1;
    tick();
    hdng_vld = 1'b0;
    chk("t5_ovr",  int'(bus0.ovr), 1);
    chk("t5_busy", int'(bus0.busy), 1);
    repeat (3) tick();
    chk("t5_PID0", int'(bus0.PID), 366);

    // Reset in the middle of a sequence
    send(12'h0A0, 12'h000, 1'b1, 9'd0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_PID",     int'(bus0.PID), 0);
    chk("t6_err_sat", int'(bus0.err_sat), 0);
    chk("t6_busy",    int'(bus0.busy), 0);
    chk("t6_ovr",     int'(bus0.ovr), 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    send(12'h0A0, 12'h000, 1'b1, 9'd0);
    repeat (5) tick();
    chk("t6_pid_vld", int'(bus0.pid_vld), 1);
    chk("t6_PID_new", int'(bus0.PID), 606);

    // Random traffic: arbitrary spacing, moving, I_term, occasional resets
    for (int c = 0; c < 2000; c++) begin
      I_term = 9'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        hdng_vld = ($urandom_range(0, 4) == 0);
        if (hdng_vld) begin
          dsrd_hdng = 12'($urandom);
          heading   = 12'(dsrd_hdng + 12'($urandom_range(0, 1400)) - 12'd700);
          moving    = ($urandom_range(0, 3) != 0);
        end
        tick();
      end
    end
    hdng_vld = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
